// File: rtl/seq_bit_streamer_if.sv
// rtl/seq_bit_streamer_if.sv - word handshake between a producer and seq_bit_streamer
interface seq_bit_streamer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_bit_streamer.sv
// rtl/seq_bit_streamer.sv - parallel-to-serial front end feeding the sequence detector
module seq_bit_streamer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    seq_bit_streamer_if.slave in_if,
    input  logic              hold,
    output logic              x,
    output logic              enable,
    output logic              word_done,
    output logic              busy
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             buf_full_q, buf_full_d;
    logic             ready_q, ready_d;
    logic             x_q, x_d;
    logic             enable_q, enable_d;

    logic             accept;
    logic             load;
    logic             buf_head, sh_head;
    logic [WIDTH-1:0] buf_rest, sh_rest;

    // Outgoing bit and remaining bits of the buffer and the shifter, in the configured bit order.
    always_comb begin
        if (MSB_FIRST) begin
            buf_head = buf_q[WIDTH-1];
            buf_rest = buf_q << 1;
            sh_head  = sh_q[WIDTH-1];
            sh_rest  = sh_q << 1;
        end else begin
            buf_head = buf_q[0];
            buf_rest = buf_q >> 1;
            sh_head  = sh_q[0];
            sh_rest  = sh_q >> 1;
        end
    end

    // Handshake into the buffer, buffer-to-shifter transfer and per-bit stepping.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        enable_d   = 1'b0;
        load       = 1'b0;
        accept     = in_if.in_valid & ready_q;

        // ready_q is only high while the buffer is empty, so accept and load never coincide.
        if (accept) begin
            buf_d      = in_if.in_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q && !hold) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (cnt_q == LAST) begin
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        x_d      = sh_head;
                        sh_d     = sh_rest;
                        enable_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = SHIFT;
            buf_full_d = 1'b0;
            cnt_d      = '0;
            x_d        = buf_head;
            sh_d       = buf_rest;
            enable_d   = 1'b1;
        end

        ready_d = ~buf_full_d;
    end

    // State registers; reset discards both the partial word and the buffered word at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            x_q        <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            x_q        <= x_d;
            enable_q   <= enable_d;
        end
    end

    assign in_if.in_ready = ready_q;
    assign x              = x_q;
    assign enable         = enable_q;
    assign word_done      = enable_q & (cnt_q == LAST);
    assign busy           = (state_q == SHIFT) | buf_full_q;
endmodule
